// File: rtl/hs32_intctl_pkg.sv
// hs32_intctl_pkg: register offsets, CTRL bit positions and FSM encoding for the interrupt controller
package hs32_intctl_pkg;

    localparam logic [5:0] REG_TBL     = 6'h00;
    localparam logic [5:0] REG_ENABLE  = 6'h20;
    localparam logic [5:0] REG_PENDING = 6'h21;
    localparam logic [5:0] REG_CTRL    = 6'h22;

    localparam int CTRL_GIE      = 0;
    localparam int CTRL_NMI_PEND = 1;

    localparam int NMI_VEC_DEF = 24;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/hs32_prio24.sv
// hs32_prio24: combinational lowest-index-wins priority encoder over 24 requests
module hs32_prio24 (
    input  logic [23:0] req,
    output logic        valid,
    output logic [4:0]  idx
);

    assign valid = |req;

    // scan from the top so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        for (int i = 23; i >= 0; i--)
            if (req[i]) idx = 5'(i);
    end

endmodule

// File: rtl/hs32_intctl.sv
// hs32_intctl: 24-line + NMI interrupt controller with handler table; NMI path enabled by HS32_INTCTL_NMI_EN
module hs32_intctl
    import hs32_intctl_pkg::*;
#(
    parameter int NLINES  = 24,
    parameter int NMI_VEC = NMI_VEC_DEF
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic [NLINES-1:0] lines,
    input  logic              nmi_in,
    output logic              intrq,
    output logic [4:0]        vec,
    output logic [31:0]       handler,
    output logic              nmi,
    input  logic              iack,
    input  logic [7:0]        addr,
    input  logic              rw,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    input  logic              stb,
    output logic              ack
);

    logic [31:0]       tbl [32];
    logic [NLINES-1:0] lines_q, pend, en, cand, clr_pend;
    logic              gie, nmi_req, cand_valid, take, done, acc, wr;
    logic [4:0]        cand_idx, sel, next_vec;
    logic [5:0]        word;
    logic [31:0]       rdata;
    state_t            state, state_d;

    assign word     = addr[7:2];
    assign acc      = stb & ~ack;
    assign wr       = acc & rw;
    assign cand     = gie ? pend & en : '0;
    assign next_vec = nmi_req ? 5'(NMI_VEC) : cand_idx;
    assign intrq    = state == REQ;
    assign clr_pend = (wr && word == REG_PENDING ? din[NLINES-1:0] : '0)
                    | (done && !nmi ? NLINES'(1) << sel : '0);

    hs32_prio24 u_prio (
        .req   (cand),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

`ifdef HS32_INTCTL_NMI_EN
    logic nmi_q, nmi_pend;
    assign nmi_req = nmi_pend;
    // NMI edge capture; a new edge beats the acknowledge clear
    always_ff @(posedge i_clk) begin
        if (reset) begin
            nmi_q    <= nmi_in;
            nmi_pend <= 1'b0;
            nmi      <= 1'b0;
        end else begin
            nmi_q    <= nmi_in;
            nmi_pend <= (nmi_in & ~nmi_q) | (nmi_pend & ~(done & nmi));
            if (take) nmi <= nmi_pend;
        end
    end
    logic unused_ok;
    assign unused_ok = ^addr[1:0];
`else
    assign nmi_req = 1'b0;
    assign nmi     = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{addr[1:0], nmi_in};
`endif

    // read mux for the register map; unmapped offsets read 0
    always_comb begin
        rdata = (word & 6'h20) == REG_TBL ? tbl[word[4:0]]
              : word == REG_ENABLE        ? 32'(en)
              : word == REG_PENDING       ? 32'(pend)
              : word == REG_CTRL          ? 32'({nmi_req, gie})
              :                             32'd0;
    end

    // next-state: take a request from IDLE, release it on iack
    always_comb begin
        state_d = state;
        take    = 1'b0;
        done    = 1'b0;
        if (state == IDLE && (nmi_req || cand_valid)) begin
            state_d = REQ;
            take    = 1'b1;
        end else if (state == REQ && iack) begin
            state_d = IDLE;
            done    = 1'b1;
        end
    end

    // state register and frozen request outputs
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state   <= IDLE;
            vec     <= '0;
            handler <= '0;
            sel     <= '0;
        end else begin
            state <= state_d;
            if (take) begin
                vec     <= next_vec;
                handler <= tbl[next_vec];
                sel     <= cand_idx;
            end
        end
    end

    // edge capture, bus slave and register file; pending sets beat clears
    always_ff @(posedge i_clk) begin
        if (reset) begin
            lines_q <= lines;
            pend    <= '0;
            en      <= '0;
            gie     <= 1'b0;
            ack     <= 1'b0;
            dout    <= '0;
            for (int i = 0; i < 32; i++) tbl[i] <= '0;
        end else begin
            lines_q <= lines;
            pend    <= (pend & ~clr_pend) | (lines & ~lines_q);
            ack     <= acc;
            dout    <= acc && !rw ? rdata : '0;
            if (wr && (word & 6'h20) == REG_TBL) tbl[word[4:0]] <= din;
            if (wr && word == REG_ENABLE) en <= din[NLINES-1:0];
            if (wr && word == REG_CTRL) gie <= din[CTRL_GIE];
        end
    end

endmodule

// File: tb/tb_hs32_intctl.sv
// tb_hs32_intctl: scoreboard bench for hs32_intctl (bus reads and interrupt requests)
module tb_hs32_intctl;

    logic        i_clk = 1'b0, reset = 1'b1, nmi_in = 1'b0, iack = 1'b0, rw = 1'b0, stb = 1'b0;
    logic [23:0] lines = '0;
    logic [7:0]  addr = '0;
    logic [31:0] din = '0;
    logic        intrq, nmi, ack;
    logic [4:0]  vec;
    logic [31:0] handler, dout;

    int total = 0, bad = 0;
    logic [31:0] bus_q [$];
    logic [37:0] req_q [$];
    logic [37:0] e_req;
    logic        prev_intrq = 1'b0;

    hs32_intctl dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .lines   (lines),
        .nmi_in  (nmi_in),
        .intrq   (intrq),
        .vec     (vec),
        .handler (handler),
        .nmi     (nmi),
        .iack    (iack),
        .addr    (addr),
        .rw      (rw),
        .din     (din),
        .dout    (dout),
        .stb     (stb),
        .ack     (ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] rq(input logic n, input logic [4:0] v, input logic [31:0] h);
        return {n, v, h};
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [31:0] exp);
        bus_q.push_back(w ? 32'd0 : exp);
        addr = a; rw = w; din = d; stb = 1'b1;
        tick;
        stb = 1'b0;
        tick;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus(a, 1'b1, d, 32'd0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        bus(a, 1'b0, 32'd0, exp);
    endtask

    task automatic do_iack;
        iack = 1'b1;
        tick;
        iack = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (ack) begin
            if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
            else chk("bus_dout", dout, bus_q.pop_front());
        end
        if (intrq && !prev_intrq) begin
            if (req_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
            else begin
                e_req = req_q.pop_front();
                chk("req_vec", 32'(vec), 32'(e_req[36:32]));
                chk("req_handler", handler, e_req[31:0]);
                chk("req_nmi", 32'(nmi), 32'(e_req[37]));
            end
        end
        prev_intrq <= intrq;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        tick; tick;
        reset = 1'b0;
        chk("rst_intrq", 32'(intrq), 0);
        chk("rst_vec", 32'(vec), 0);
        chk("rst_handler", handler, 0);
        chk("rst_nmi", 32'(nmi), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dout", dout, 0);

        // single line with 2-cycle latency
        wr(8'h08, 32'h1000);
        wr(8'h80, 32'h4);
        wr(8'h88, 32'h1);
        req_q.push_back(rq(1'b0, 5'd2, 32'h1000));
        lines[2] = 1'b1;
        tick;
        chk("single_lat_k", 32'(intrq), 0);
        tick;
        chk("single_lat_k1", 32'(intrq), 1);
        chk("single_vec", 32'(vec), 2);
        chk("single_handler", handler, 32'h1000);
        lines = '0;
        do_iack;
        chk("single_iack_drop", 32'(intrq), 0);
        rd(8'h84, 32'h0);

        // priority: 3 before 5, 5 one idle cycle later
        wr(8'h0C, 32'h3000);
        wr(8'h14, 32'h5000);
        wr(8'h80, 32'h28);
        req_q.push_back(rq(1'b0, 5'd3, 32'h3000));
        req_q.push_back(rq(1'b0, 5'd5, 32'h5000));
        lines[5] = 1'b1; lines[3] = 1'b1;
        tick; tick;
        chk("prio_first", 32'(vec), 3);
        lines = '0;
        do_iack;
        chk("prio_idle", 32'(intrq), 0);
        tick;
        chk("prio_second_rq", 32'(intrq), 1);
        chk("prio_second", 32'(vec), 5);
        do_iack;
        rd(8'h84, 32'h0);

        // masking and write-1-to-clear
        wr(8'h80, 32'h0);
        lines[7] = 1'b1;
        tick;
        lines = '0;
        tick; tick;
        chk("mask_no_req", 32'(intrq), 0);
        rd(8'h84, 32'h80);
        wr(8'h84, 32'h80);
        rd(8'h84, 32'h0);
        rd(8'h88, 32'h1);
        rd(8'h8C, 32'h0);

        // NMI precedence with GIE=0 and line 0 pending
        wr(8'h60, 32'hA000);
        wr(8'h88, 32'h0);
        wr(8'h80, 32'h1);
        lines[0] = 1'b1;
        tick;
        lines = '0;
        tick;
`ifdef HS32_INTCTL_NMI_EN
        req_q.push_back(rq(1'b1, 5'd24, 32'hA000));
`endif
        nmi_in = 1'b1;
        tick; tick;
`ifdef HS32_INTCTL_NMI_EN
        chk("nmi_intrq", 32'(intrq), 1);
        chk("nmi_flag", 32'(nmi), 1);
        chk("nmi_vec", 32'(vec), 24);
        nmi_in = 1'b0;
        rd(8'h88, 32'h2);
        do_iack;
        chk("nmi_iack_drop", 32'(intrq), 0);
`else
        chk("nmi_off_no_req", 32'(intrq), 0);
        nmi_in = 1'b0;
`endif
        rd(8'h88, 32'h0);
        rd(8'h84, 32'h1);
        wr(8'h84, 32'h1);
        rd(8'h84, 32'h0);

        // set beats clear on iack
        wr(8'h04, 32'h1111);
        wr(8'h80, 32'h2);
        wr(8'h88, 32'h1);
        req_q.push_back(rq(1'b0, 5'd1, 32'h1111));
        req_q.push_back(rq(1'b0, 5'd1, 32'h1111));
        lines[1] = 1'b1;
        tick;
        lines = '0;
        tick;
        chk("sbc_first", 32'(intrq), 1);
        lines[1] = 1'b1;
        do_iack;
        lines = '0;
        chk("sbc_drop", 32'(intrq), 0);
        tick;
        chk("sbc_again", 32'(intrq), 1);
        rd(8'h84, 32'h2);
        do_iack;
        rd(8'h84, 32'h0);

        // reset during REQ with a line held high through reset
        wr(8'h10, 32'h4444);
        wr(8'h80, 32'h10);
        req_q.push_back(rq(1'b0, 5'd4, 32'h4444));
        lines[4] = 1'b1;
        tick; tick;
        chk("mid_req", 32'(intrq), 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_intrq", 32'(intrq), 0);
        chk("mid_rst_vec", 32'(vec), 0);
        chk("mid_rst_handler", handler, 0);
        chk("mid_rst_nmi", 32'(nmi), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_dout", dout, 0);
        wr(8'h80, 32'h10);
        wr(8'h88, 32'h1);
        tick; tick;
        chk("held_line_no_req", 32'(intrq), 0);
        rd(8'h84, 32'h0);
        rd(8'h10, 32'h0);
        lines = '0;
        tick;
        chk("bus_q_empty", 32'(bus_q.size()), 0);
        chk("req_q_empty", 32'(req_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
